lb_feeder: RTL and testbench

- Transmitter side of the line-buffer stream interface: reads a feature-map tile from the activation SRAM and emits 9-lane words, one per cycle, with valid/ready.
- Per layer_code, inserts zero padding rows at the top and bottom of the frame so the downstream 3-row window generator sees full windows at the frame edges.
- Sits between the activation SRAM and the line buffer, in front of the conv datapath.

---
 rtl/lb_feeder_pkg.sv | 21 ++
 rtl/lb_feeder_fifo.sv | 59 +++++
 rtl/lb_feeder.sv | 176 +++++++++++++++++
 tb/tb_lb_feeder.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_feeder_pkg.sv
// Shared definitions for the line-buffer feeder.
// layer_code field layout (also decoded by the line-buffer address generator):
//   [9:0] W words per row, [18:10] H data rows, [19] pad_en.
// Also holds the feeder FSM state encoding.
package lb_feeder_pkg;

    localparam int unsigned W_LSB   = 0;
    localparam int unsigned W_BITS  = 10;
    localparam int unsigned H_LSB   = 10;
    localparam int unsigned H_BITS  = 9;
    localparam int unsigned PAD_BIT = 19;

    typedef enum logic [2:0] {
        StIdle,
        StPadTop,
        StData,
        StPadBot,
        StDrain
    } feeder_state_e;

endpackage

// File: rtl/lb_feeder_fifo.sv
// Output skid FIFO for lb_feeder. Synchronous, first-word fall-through read.
// Ports:
//   clk, reset    clock, synchronous active-low reset (flushes pointers/count)
//   push, wdata   write strobe and entry (ignored when full)
//   pop           read strobe (ignored when empty)
//   rdata         head entry, valid while empty==0
//   empty, count  status and occupancy
module lb_feeder_fifo #(
    parameter int unsigned depth = 4,
    parameter int unsigned width = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [width-1:0]         wdata,
    input  logic                     pop,
    output logic [width-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(depth):0]   count
);

    localparam int unsigned ptr_bits = $clog2(depth);
    localparam logic [ptr_bits:0] full_count = (ptr_bits + 1)'(depth);

    logic [width-1:0]    mem_q [depth];
    logic [ptr_bits-1:0] wr_ptr_q, rd_ptr_q;
    logic [ptr_bits:0]   count_q;
    logic                do_push, do_pop;

    assign do_push = push && (count_q != full_count);
    assign do_pop  = pop && (count_q != '0);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + ptr_bits'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + ptr_bits'(1);
            if (do_push && !do_pop) begin
                count_q <= count_q + (ptr_bits + 1)'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - (ptr_bits + 1)'(1);
            end
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/lb_feeder.sv
// Line-buffer feeder: reads a tile from the activation SRAM and streams 9-lane
// words with valid/ready, adding W-word zero rows above and below when pad_en.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   start, layer_code, base_addr   frame request (accepted only when busy==0)
//   mem_re, mem_addr, mem_rdata    SRAM read port, data one cycle after mem_re
//   out, valid, ready          output stream; row_last/frame_last qualify words
//   busy, done                 frame in progress / one-cycle completion pulse
module lb_feeder
    import lb_feeder_pkg::*;
#(
    parameter int unsigned int_bits   = 13,
    parameter int unsigned LC_bits    = 20,
    parameter int unsigned ADDR_bits  = 12,
    parameter int unsigned FIFO_depth = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [LC_bits-1:0]            layer_code,
    input  logic [ADDR_bits-1:0]          base_addr,
    output logic                          mem_re,
    output logic [ADDR_bits-1:0]          mem_addr,
    input  logic [9*int_bits-1:0]         mem_rdata,
    output logic [8:0][int_bits-1:0]      out,
    output logic                          valid,
    input  logic                          ready,
    output logic                          row_last,
    output logic                          frame_last,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned data_bits = 9 * int_bits;
    localparam int unsigned cnt_bits  = $clog2(FIFO_depth) + 1;
    localparam int unsigned row_bits  = H_BITS + 1;

    feeder_state_e         state_q, state_d;
    logic [W_BITS-1:0]     w_q, w_d, col_q, col_d;
    logic [H_BITS-1:0]     h_q, h_d;
    logic                  pad_q, pad_d;
    logic [row_bits-1:0]   row_q, row_d, rows_total, last_row, data_last_row;
    logic [ADDR_bits-1:0]  addr_q, addr_d;
    logic                  done_q, done_d;
    // Slot issued last cycle; its word is written to the FIFO this cycle.
    logic                  infl_q, infl_pad_q, infl_rl_q, infl_fl_q;

    logic                  issue_state, issue, col_end, frame_end, drain_ok;
    logic [cnt_bits:0]     occ;
    logic                  fifo_pop, fifo_empty;
    logic [cnt_bits-1:0]   fifo_count;
    logic [data_bits+1:0]  fifo_wdata, fifo_rdata;

    assign rows_total    = {1'b0, h_q} + {{(row_bits - 2){1'b0}}, pad_q, 1'b0};
    assign last_row      = rows_total - row_bits'(1);
    assign data_last_row = pad_q ? {1'b0, h_q} : {1'b0, h_q} - row_bits'(1);

    assign issue_state = (state_q == StPadTop) || (state_q == StData) || (state_q == StPadBot);
    // Credit check counts the in-flight slot so the FIFO can never overflow.
    assign occ       = {1'b0, fifo_count} + (cnt_bits + 1)'(infl_q);
    assign issue     = issue_state && (occ < (cnt_bits + 1)'(FIFO_depth));
    assign col_end   = (col_q == w_q - W_BITS'(1));
    assign frame_end = col_end && (row_q == last_row);

    assign fifo_pop = !fifo_empty && ready;
    // Finish in the same cycle the final word leaves so done follows it by one cycle.
    assign drain_ok = !infl_q && (fifo_empty || (fifo_count == cnt_bits'(1) && fifo_pop));

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        h_d     = h_q;
        pad_d   = pad_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // done_q high means busy is still asserted this cycle.
                if (start && !done_q) begin
                    w_d    = layer_code[W_LSB +: W_BITS];
                    h_d    = layer_code[H_LSB +: H_BITS];
                    pad_d  = layer_code[PAD_BIT];
                    addr_d = base_addr;
                    col_d  = '0;
                    row_d  = '0;
                    if (w_d == '0 || h_d == '0) begin
                        state_d = StDrain;
                    end else if (pad_d) begin
                        state_d = StPadTop;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StPadTop, StData, StPadBot: begin
                if (issue) begin
                    col_d = col_end ? '0 : col_q + W_BITS'(1);
                    if (col_end) row_d = row_q + row_bits'(1);
                    if (state_q == StData) addr_d = addr_q + ADDR_bits'(1);
                    if (state_q == StPadTop && col_end) begin
                        state_d = StData;
                    end else if (state_q == StData && col_end && row_q == data_last_row) begin
                        state_d = pad_q ? StPadBot : StDrain;
                    end else if (state_q == StPadBot && frame_end) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (drain_ok) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            w_q        <= '0;
            h_q        <= '0;
            pad_q      <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            done_q     <= 1'b0;
            infl_q     <= 1'b0;
            infl_pad_q <= 1'b0;
            infl_rl_q  <= 1'b0;
            infl_fl_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            h_q        <= h_d;
            pad_q      <= pad_d;
            col_q      <= col_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            done_q     <= done_d;
            infl_q     <= issue;
            infl_pad_q <= (state_q != StData);
            infl_rl_q  <= col_end;
            infl_fl_q  <= frame_end;
        end
    end

    assign fifo_wdata = {infl_fl_q, infl_rl_q,
                         infl_pad_q ? {data_bits{1'b0}} : mem_rdata};

    lb_feeder_fifo #(
        .depth (FIFO_depth),
        .width (data_bits + 2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (infl_q),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign valid    = !fifo_empty;
    // Mask the head so stale FIFO storage never shows on the outputs.
    assign {frame_last, row_last, out} = valid ? fifo_rdata : '0;
    assign mem_re   = issue && (state_q == StData);
    assign mem_addr = addr_q;
    assign busy     = (state_q != StIdle) || done_q;
    assign done     = done_q;

endmodule

// File: tb/tb_lb_feeder.sv
module tb_lb_feeder;

    localparam int IB = 13;
    localparam int DB = 9 * IB;

    typedef struct {
        logic [DB-1:0] data;
        logic          rl;
        logic          fl;
        int            cyc;
    } word_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 start = 1'b0;
    logic                 ready = 1'b1;
    logic [19:0]          layer_code = '0;
    logic [11:0]          base_addr = '0;
    logic                 mem_re;
    logic [11:0]          mem_addr;
    logic [DB-1:0]        mem_rdata = '0;
    logic [8:0][IB-1:0]   out_w;
    logic                 valid, row_last, frame_last, busy, done;

    int total = 0;
    int bad = 0;
    int ncyc = 0;
    bit rand_ready = 1'b0;

    word_t got_q[$];
    word_t exp_q[$];
    int    re_addr_q[$];
    int    re_cyc_q[$];
    int    done_cyc_q[$];
    int    start_cyc, busy_cnt, valid_cnt, stall_viol, max_occ;
    logic  prev_stall = 1'b0;
    logic [DB+1:0] prev_word;

    always #5 clk = ~clk;

    lb_feeder dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .layer_code (layer_code),
        .base_addr  (base_addr),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .out        (out_w),
        .valid      (valid),
        .ready      (ready),
        .row_last   (row_last),
        .frame_last (frame_last),
        .busy       (busy),
        .done       (done)
    );

    // SRAM word k holds lane i = k*16+i.
    function automatic logic [DB-1:0] sram_word(input int k);
        logic [DB-1:0] w;
        for (int i = 0; i < 9; i++) w[i*IB +: IB] = IB'(k * 16 + i);
        return w;
    endfunction

    // SRAM model; returns junk when not read so pad slots must be forced to zero.
    always @(posedge clk) begin : sram_model
        logic [DB-1:0] junk;
        for (int i = 0; i < 9; i++) junk[i*IB +: IB] = IB'($urandom);
        mem_rdata <= mem_re ? sram_word(int'(mem_addr)) : junk;
    end

    // Monitor samples on the falling edge.
    always @(negedge clk) begin : monitor
        word_t w;
        ncyc++;
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!valid || {frame_last, row_last, out_w} !== prev_word)) begin
                stall_viol++;
            end
            prev_stall = valid && !ready;
            prev_word  = {frame_last, row_last, out_w};
            if (valid && ready) begin
                w.data = out_w;
                w.rl   = row_last;
                w.fl   = frame_last;
                w.cyc  = ncyc;
                got_q.push_back(w);
            end
            if (mem_re) begin
                re_addr_q.push_back(int'(mem_addr));
                re_cyc_q.push_back(ncyc);
            end
            if (done) done_cyc_q.push_back(ncyc);
            if (start && !busy) start_cyc = ncyc;
            if (busy) busy_cnt++;
            if (valid) valid_cnt++;
            if (int'(dut.fifo_count) > max_occ) max_occ = int'(dut.fifo_count);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        re_addr_q.delete();
        re_cyc_q.delete();
        done_cyc_q.delete();
        start_cyc  = -1;
        busy_cnt   = 0;
        valid_cnt  = 0;
        stall_viol = 0;
        max_occ    = 0;
    endtask

    // Builds the expected stream from the frame rules, then runs the frame.
    task automatic run_frame(input int w, input int h, input bit pad, input int base);
        int k = 0;
        clear_mon();
        exp_q.delete();
        if (w > 0 && h > 0) begin
            for (int r = 0; r < h + 2 * pad; r++) begin
                for (int c = 0; c < w; c++) begin
                    word_t e;
                    bit is_pad;
                    is_pad = pad && (r == 0 || r == h + 1);
                    e.data = is_pad ? '0 : sram_word((base + k) % 4096);
                    if (!is_pad) k++;
                    e.rl  = (c == w - 1);
                    e.fl  = (c == w - 1) && (r == h + 2 * pad - 1);
                    e.cyc = 0;
                    exp_q.push_back(e);
                end
            end
        end
        layer_code = {pad, 9'(h), 10'(w)};
        base_addr  = 12'(base);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3000 && done_cyc_q.size() == 0; i++) tick();
        total++;
        if (done_cyc_q.size() == 0) begin
            bad++;
            $display("FAIL frame_timeout w=%0d h=%0d got=no done want=done", w, h);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) tick();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
        total++; if (out_w !== '0) begin bad++; $display("FAIL reset_out got=%h want=0", out_w); end
        total++; if (mem_re !== 1'b0) begin bad++; $display("FAIL reset_mem_re got=%b want=0", mem_re); end
        total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
        total++; if (row_last !== 1'b0) begin bad++; $display("FAIL reset_row_last got=%b want=0", row_last); end
        total++; if (frame_last !== 1'b0) begin bad++; $display("FAIL reset_frame_last got=%b want=0", frame_last); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int f, l;
        rand_ready = 1'b0;
        run_frame(4, 2, 1'b0, 'h010);
        total++; if (got_q.size() !== 8) begin bad++; $display("FAIL basic_count got=%0d want=8", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].rl !== exp_q[i].rl || got_q[i].fl !== exp_q[i].fl) begin
                bad++;
                $display("FAIL basic_word%0d got=%h rl=%b fl=%b want=%h rl=%b fl=%b", i,
                         got_q[i].data, got_q[i].rl, got_q[i].fl, exp_q[i].data, exp_q[i].rl, exp_q[i].fl);
            end
        end
        f = (got_q.size() > 0) ? got_q[0].cyc : -100;
        l = (got_q.size() >= 8) ? got_q[7].cyc : -100;
        total++; if (l - f !== 7) begin bad++; $display("FAIL basic_span got=%0d want=7", l - f); end
        total++;
        if (re_cyc_q.size() == 0 || f - re_cyc_q[0] !== 2) begin
            bad++; $display("FAIL basic_first_latency got=%0d want=2", (re_cyc_q.size() > 0) ? f - re_cyc_q[0] : -1);
        end
        total++;
        if (done_cyc_q.size() == 0 || done_cyc_q[0] - l !== 1) begin
            bad++; $display("FAIL basic_done_delay got=%0d want=1", (done_cyc_q.size() > 0) ? done_cyc_q[0] - l : -1);
        end
    endtask

    task automatic test_pad();
        int f, l;
        rand_ready = 1'b0;
        run_frame(3, 2, 1'b1, 0);
        total++; if (got_q.size() !== 12) begin bad++; $display("FAIL pad_count got=%0d want=12", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].rl !== exp_q[i].rl || got_q[i].fl !== exp_q[i].fl) begin
                bad++;
                $display("FAIL pad_word%0d got=%h rl=%b fl=%b want=%h rl=%b fl=%b", i,
                         got_q[i].data, got_q[i].rl, got_q[i].fl, exp_q[i].data, exp_q[i].rl, exp_q[i].fl);
            end
        end
        f = (got_q.size() > 0) ? got_q[0].cyc : -100;
        l = (got_q.size() >= 12) ? got_q[11].cyc : -100;
        total++; if (l - f !== 11) begin bad++; $display("FAIL pad_span got=%0d want=11", l - f); end
    endtask

    task automatic test_random_ready();
        rand_ready = 1'b1;
        run_frame(4, 2, 1'b0, 'h010);
        rand_ready = 1'b0;
        total++; if (got_q.size() !== 8) begin bad++; $display("FAIL rready_count got=%0d want=8", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].rl !== exp_q[i].rl || got_q[i].fl !== exp_q[i].fl) begin
                bad++;
                $display("FAIL rready_word%0d got=%h rl=%b fl=%b want=%h rl=%b fl=%b", i,
                         got_q[i].data, got_q[i].rl, got_q[i].fl, exp_q[i].data, exp_q[i].rl, exp_q[i].fl);
            end
        end
        total++; if (stall_viol !== 0) begin bad++; $display("FAIL rready_stable got=%0d want=0", stall_viol); end
        total++; if (max_occ > 4) begin bad++; $display("FAIL rready_occupancy got=%0d want<=4", max_occ); end
    endtask

    task automatic test_wrap();
        rand_ready = 1'b0;
        run_frame(4, 1, 1'b0, 'hFFE);
        total++; if (re_addr_q.size() !== 4) begin bad++; $display("FAIL wrap_reads got=%0d want=4", re_addr_q.size()); end
        for (int i = 0; i < 4 && i < re_addr_q.size(); i++) begin
            total++;
            if (re_addr_q[i] !== (('hFFE + i) % 4096)) begin
                bad++; $display("FAIL wrap_addr%0d got=%h want=%h", i, re_addr_q[i], ('hFFE + i) % 4096);
            end
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i].data !== exp_q[i].data) begin
                bad++; $display("FAIL wrap_word%0d got=%h want=%h", i, got_q[i].data, exp_q[i].data);
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        rand_ready = 1'b0;
        clear_mon();
        layer_code = {1'b0, 9'd4, 10'd8};
        base_addr  = 12'h100;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        reset = 1'b0;
        tick();
        total++;
        if ({valid, out_w, mem_re, mem_addr, row_last, frame_last, busy, done} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got=v%b re%b a%h rl%b fl%b b%b d%b out=%h want=all 0",
                     valid, mem_re, mem_addr, row_last, frame_last, busy, done, out_w);
        end
        reset = 1'b1;
        tick();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL midreset_no_stale got=%b want=0", valid); end
        base = int'($urandom_range(0, 4095));
        run_frame(2, 1, 1'b0, base);
        total++; if (got_q.size() !== 2) begin bad++; $display("FAIL midreset_count got=%0d want=2", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].rl !== exp_q[i].rl || got_q[i].fl !== exp_q[i].fl) begin
                bad++;
                $display("FAIL midreset_word%0d got=%h rl=%b fl=%b want=%h rl=%b fl=%b", i,
                         got_q[i].data, got_q[i].rl, got_q[i].fl, exp_q[i].data, exp_q[i].rl, exp_q[i].fl);
            end
        end
    endtask

    task automatic test_degenerate();
        rand_ready = 1'b0;
        clear_mon();
        layer_code = {1'b0, 9'd5, 10'd0};
        base_addr  = 12'h000;
        // start held for three cycles: the 2nd is while busy, the 3rd coincides with done.
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        repeat (6) tick();
        total++; if (done_cyc_q.size() !== 1) begin bad++; $display("FAIL degen_done_count got=%0d want=1", done_cyc_q.size()); end
        total++;
        if (done_cyc_q.size() == 0 || done_cyc_q[0] - start_cyc !== 2) begin
            bad++; $display("FAIL degen_done_delay got=%0d want=2", (done_cyc_q.size() > 0) ? done_cyc_q[0] - start_cyc : -1);
        end
        total++; if (busy_cnt !== 2) begin bad++; $display("FAIL degen_busy_cycles got=%0d want=2", busy_cnt); end
        total++; if (valid_cnt !== 0) begin bad++; $display("FAIL degen_valid got=%0d want=0", valid_cnt); end
        total++; if (re_cyc_q.size() !== 0) begin bad++; $display("FAIL degen_mem_re got=%0d want=0", re_cyc_q.size()); end
    endtask

    task automatic test_random_frames();
        int w, h, base;
        bit pad;
        for (int n = 0; n < 5; n++) begin
            w    = int'($urandom_range(1, 5));
            h    = int'($urandom_range(1, 3));
            pad  = 1'($urandom_range(0, 1));
            base = int'($urandom_range(0, 4095));
            rand_ready = 1'b1;
            run_frame(w, h, pad, base);
            rand_ready = 1'b0;
            total++;
            if (got_q.size() !== exp_q.size()) begin
                bad++; $display("FAIL rand%0d_count got=%0d want=%0d", n, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                total++;
                if (got_q[i].data !== exp_q[i].data || got_q[i].rl !== exp_q[i].rl || got_q[i].fl !== exp_q[i].fl) begin
                    bad++;
                    $display("FAIL rand%0d_word%0d got=%h rl=%b fl=%b want=%h rl=%b fl=%b", n, i,
                             got_q[i].data, got_q[i].rl, got_q[i].fl, exp_q[i].data, exp_q[i].rl, exp_q[i].fl);
                end
            end
            total++; if (stall_viol !== 0) begin bad++; $display("FAIL rand%0d_stable got=%0d want=0", n, stall_viol); end
            total++; if (max_occ > 4) begin bad++; $display("FAIL rand%0d_occupancy got=%0d want<=4", n, max_occ); end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_pad();
        test_random_ready();
        test_wrap();
        test_reset_mid();
        test_degenerate();
        test_random_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
